mem_access_unit: RTL and testbench

- Multi-cycle data-memory access stage between execute and writeback of the CPU.
- Takes the execute Result (address), rs2 store data and MemWr/MemtoReg/MemOP controls, and runs a req/gnt/rvalid transaction to the data SRAM.
- Returns sign/zero-extended load data to writeback.
- Drives stall to select_pc so PC holds while an access is outstanding.

---
 rtl/cpu_pkg.sv | 33 +++
 rtl/mem_access_unit_if.sv | 14 +
 rtl/mem_access_unit_lane_align.sv | 44 ++++
 rtl/mem_access_unit.sv | 132 +++++++++++++
 tb/tb_mem_access_unit.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions for the data-memory access stage: MemOP codes,
// access sizes, FSM state encodings, byte-enable patterns and op helpers.
package cpu_pkg;

  localparam logic [2:0] MEMOP_LB  = 3'b000;
  localparam logic [2:0] MEMOP_LH  = 3'b001;
  localparam logic [2:0] MEMOP_LW  = 3'b010;
  localparam logic [2:0] MEMOP_LBU = 3'b100;
  localparam logic [2:0] MEMOP_LHU = 3'b101;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  localparam logic [1:0] ST_IDLE       = 2'd0;
  localparam logic [1:0] ST_REQ        = 2'd1;
  localparam logic [1:0] ST_WAIT_RDATA = 2'd2;
  localparam logic [1:0] ST_DONE       = 2'd3;

  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;

  function automatic logic memop_legal(input logic [2:0] op);
    return (op == MEMOP_LB) || (op == MEMOP_LH) || (op == MEMOP_LW) ||
           (op == MEMOP_LBU) || (op == MEMOP_LHU);
  endfunction

  function automatic logic memop_misaligned(input logic [2:0] op, input logic [1:0] off);
    return ((op[1:0] == SIZE_H) && off[0]) || ((op[1:0] == SIZE_W) && (off != 2'b00));
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Data-SRAM request/grant/rvalid bus between the access unit (master) and memory (slave).
interface mem_access_unit_if #(parameter int ADDR_W = 32);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [3:0]        be;
  logic [31:0]       wdata;
  logic              gnt;
  logic              rvalid;
  logic [31:0]       rdata;

  modport master (output req, we, addr, be, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, we, addr, be, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/mem_access_unit_lane_align.sv
// Byte-lane steering: store byte enables / replicated write data, and load
// lane extraction with sign or zero extension. Purely combinational.
module mem_lane_align
  import cpu_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [1:0]  off,
  input  logic [31:0] wdata_in,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] load_data
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  // Half accesses only look at off[1]; words ignore the offset entirely.
  always_comb begin
    be        = BE_WORD;
    wdata     = wdata_in;
    load_data = rdata;
    lane_b    = rdata[{off, 3'b000} +: 8];
    lane_h    = rdata[{off[1], 4'b0000} +: 16];
    case (op[1:0])
      SIZE_B: begin
        be        = BE_BYTE << off;
        wdata     = {4{wdata_in[7:0]}};
        load_data = op[2] ? {24'b0, lane_b} : {{24{lane_b[7]}}, lane_b};
      end
      SIZE_H: begin
        be        = BE_HALF << {off[1], 1'b0};
        wdata     = {2{wdata_in[15:0]}};
        load_data = op[2] ? {16'b0, lane_h} : {{16{lane_h[15]}}, lane_h};
      end
      default: begin
        be        = BE_WORD;
        wdata     = wdata_in;
        load_data = rdata;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Multi-cycle data-memory access stage with bus timeout. Optional macro
// MEM_ACCESS_MISALIGN_EN adds a misalign output instead of forcing alignment.
module mem_access_unit
  import cpu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int ADDR_W         = 32
)
(
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              MemWr,
  input  logic              MemtoReg,
  input  logic [2:0]        MemOP,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       store_data,
  output logic              stall,
  output logic              done,
  output logic [31:0]       memory_out,
  output logic              bus_err,
`ifdef MEM_ACCESS_MISALIGN_EN
  output logic              misalign,
`endif
  mem_access_unit_if.master dmem
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [1:0]        state;
  logic [2:0]        op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       data_q;
  logic              we_q;
  logic              err_q;
  logic              mis_q;
  logic [CNT_W-1:0]  cnt;
  logic              new_access;
  logic              in_req;
  logic [3:0]        lane_be;
  logic [31:0]       lane_wdata;
  logic [31:0]       load_data;

  assign new_access = req_valid && (MemWr || MemtoReg);
  assign in_req     = (state == ST_REQ);
  assign stall      = in_req || (state == ST_WAIT_RDATA) || ((state == ST_IDLE) && new_access);
  assign done       = (state == ST_DONE);
  assign bus_err    = done && err_q;
`ifdef MEM_ACCESS_MISALIGN_EN
  assign misalign   = done && mis_q;
`endif

  mem_lane_align u_lane (
    .op        (op_q),
    .off       (addr_q[1:0]),
    .wdata_in  (data_q),
    .rdata     (dmem.rdata),
    .be        (lane_be),
    .wdata     (lane_wdata),
    .load_data (load_data)
  );

  // Bus outputs are only driven while a request is pending so reset clears them at once.
  assign dmem.req   = in_req;
  assign dmem.we    = in_req && we_q;
  assign dmem.addr  = in_req ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
  assign dmem.be    = in_req ? lane_be : 4'b0000;
  assign dmem.wdata = in_req ? lane_wdata : 32'b0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      op_q       <= 3'b000;
      addr_q     <= '0;
      data_q     <= 32'b0;
      we_q       <= 1'b0;
      err_q      <= 1'b0;
      mis_q      <= 1'b0;
      cnt        <= '0;
      memory_out <= 32'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (new_access) begin
            op_q   <= MemOP;
            addr_q <= addr;
            data_q <= store_data;
            we_q   <= MemWr;
            err_q  <= 1'b0;
            mis_q  <= 1'b0;
            if (!memop_legal(MemOP)) begin
              memory_out <= 32'b0;
              state      <= ST_DONE;
`ifdef MEM_ACCESS_MISALIGN_EN
            end else if (memop_misaligned(MemOP, addr[1:0])) begin
              mis_q <= 1'b1;
              state <= ST_DONE;
`endif
            end else begin
              state <= ST_REQ;
            end
          end
        end
        ST_REQ: begin
          if (dmem.gnt) begin
            cnt   <= '0;
            state <= we_q ? ST_DONE : ST_WAIT_RDATA;
          end
        end
        // rvalid is checked first so data on the last allowed cycle beats the timeout.
        ST_WAIT_RDATA: begin
          if (dmem.rvalid) begin
            memory_out <= load_data;
            state      <= ST_DONE;
          end else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            memory_out <= 32'b0;
            err_q      <= 1'b1;
            state      <= ST_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          err_q <= 1'b0;
          mis_q <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed, table-driven bench for mem_access_unit with hand-written timeout,
// reset, illegal-op and misalignment sequences.
module tb_mem_access_unit;
  import cpu_pkg::*;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        MemWr;
  logic        MemtoReg;
  logic [2:0]  MemOP;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic        stall;
  logic        done;
  logic [31:0] memory_out;
  logic        bus_err;
`ifdef MEM_ACCESS_MISALIGN_EN
  logic        misalign;
`endif

  int vecCount  = 0;
  int missCount = 0;

  mem_access_unit_if #(.ADDR_W(32)) dmem_bus ();

  mem_access_unit #(.TIMEOUT_CYCLES(16), .ADDR_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .MemWr      (MemWr),
    .MemtoReg   (MemtoReg),
    .MemOP      (MemOP),
    .addr       (addr),
    .store_data (store_data),
    .stall      (stall),
    .done       (done),
    .memory_out (memory_out),
    .bus_err    (bus_err),
`ifdef MEM_ACCESS_MISALIGN_EN
    .misalign   (misalign),
`endif
    .dmem       (dmem_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        we;
    logic        ld;
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic [31:0] rdata;
    int          gntDelay;
    logic [3:0]  expBe;
    logic [31:0] expAddr;
    logic [31:0] expWdata;
    logic [31:0] expOut;
  } vec_t;

  vec_t vecs[10];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vecCount++;
    if (actual !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  // One complete access: present it in IDLE, grant after gntDelay REQ cycles,
  // return rdata on the first WAIT_RDATA cycle for loads, then check DONE.
  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    req_valid  = 1'b1;
    MemWr      = v.we;
    MemtoReg   = v.ld;
    MemOP      = v.op;
    addr       = v.addr;
    store_data = v.sdata;
    #1 checkOutput({v.name, "_stall_idle"}, stall, 1);
    @(negedge clk);
    req_valid = 1'b0;
    MemWr     = 1'b0;
    MemtoReg  = 1'b0;
    for (int i = 0; i < v.gntDelay; i++) begin
      #1;
      checkOutput({v.name, "_req_hold"}, dmem_bus.req, 1);
      checkOutput({v.name, "_stall_req"}, stall, 1);
      @(negedge clk);
    end
    dmem_bus.gnt = 1'b1;
    #1;
    checkOutput({v.name, "_req"}, dmem_bus.req, 1);
    checkOutput({v.name, "_we"}, dmem_bus.we, v.we);
    checkOutput({v.name, "_addr"}, dmem_bus.addr, v.expAddr);
    checkOutput({v.name, "_be"}, dmem_bus.be, v.expBe);
    checkOutput({v.name, "_wdata"}, dmem_bus.wdata, v.expWdata);
    @(negedge clk);
    dmem_bus.gnt = 1'b0;
    if (!v.we) begin
      dmem_bus.rvalid = 1'b1;
      dmem_bus.rdata  = v.rdata;
      #1;
      checkOutput({v.name, "_req_wait"}, dmem_bus.req, 0);
      checkOutput({v.name, "_stall_wait"}, stall, 1);
      @(negedge clk);
      dmem_bus.rvalid = 1'b0;
      dmem_bus.rdata  = 32'h0;
    end
    #1;
    checkOutput({v.name, "_done"}, done, 1);
    checkOutput({v.name, "_stall_done"}, stall, 0);
    checkOutput({v.name, "_bus_err"}, bus_err, 0);
    checkOutput({v.name, "_memory_out"}, memory_out, v.expOut);
  endtask

  // Presents a load with an immediate grant and leaves the DUT in its first WAIT_RDATA cycle.
  task automatic startLoad(input logic [31:0] a);
    @(negedge clk);
    req_valid = 1'b1;
    MemtoReg  = 1'b1;
    MemWr     = 1'b0;
    MemOP     = MEMOP_LW;
    addr      = a;
    @(negedge clk);
    req_valid    = 1'b0;
    MemtoReg     = 1'b0;
    dmem_bus.gnt = 1'b1;
    @(negedge clk);
    dmem_bus.gnt = 1'b0;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int waitCycles;
`ifndef MEM_ACCESS_MISALIGN_EN
    vec_t mv;
`endif

    vecs[0] = '{"sw_word",   1'b1, 1'b0, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0,        1, 4'b1111, 32'h100, 32'hDEADBEEF, 32'h00000000};
    vecs[1] = '{"lb_off3",   1'b0, 1'b1, 3'b000, 32'h203, 32'h0,        32'h80123456, 0, 4'b1000, 32'h200, 32'h00000000, 32'hFFFFFF80};
    vecs[2] = '{"lbu_off3",  1'b0, 1'b1, 3'b100, 32'h203, 32'h0,        32'h80123456, 0, 4'b1000, 32'h200, 32'h00000000, 32'h00000080};
    vecs[3] = '{"sh_hi",     1'b1, 1'b0, 3'b001, 32'h302, 32'h0000ABCD, 32'h0,        0, 4'b1100, 32'h300, 32'hABCDABCD, 32'h00000080};
    vecs[4] = '{"lhu_hi",    1'b0, 1'b1, 3'b101, 32'h302, 32'h0,        32'hABCD0000, 1, 4'b1100, 32'h300, 32'h00000000, 32'h0000ABCD};
    vecs[5] = '{"lh_lo",     1'b0, 1'b1, 3'b001, 32'h300, 32'h0,        32'h12348001, 0, 4'b0011, 32'h300, 32'h00000000, 32'hFFFF8001};
    vecs[6] = '{"sb_off1",   1'b1, 1'b0, 3'b000, 32'h101, 32'h000000A5, 32'h0,        2, 4'b0010, 32'h100, 32'hA5A5A5A5, 32'hFFFF8001};
    vecs[7] = '{"lw_word",   1'b0, 1'b1, 3'b010, 32'h404, 32'h0,        32'hCAFEF00D, 0, 4'b1111, 32'h404, 32'h00000000, 32'hCAFEF00D};
    vecs[8] = '{"lb_off2",   1'b0, 1'b1, 3'b000, 32'h202, 32'h0,        32'h007F0000, 1, 4'b0100, 32'h200, 32'h00000000, 32'h0000007F};
    vecs[9] = '{"sw_prio",   1'b1, 1'b1, 3'b010, 32'h500, 32'h11223344, 32'h0,        0, 4'b1111, 32'h500, 32'h11223344, 32'h0000007F};

    rst             = 1'b0;
    req_valid       = 1'b0;
    MemWr           = 1'b0;
    MemtoReg        = 1'b0;
    MemOP           = 3'b000;
    addr            = 32'h0;
    store_data      = 32'h0;
    dmem_bus.gnt    = 1'b0;
    dmem_bus.rvalid = 1'b0;
    dmem_bus.rdata  = 32'h0;

    repeat (2) @(negedge clk);
    checkOutput("reset_stall", stall, 0);
    checkOutput("reset_done", done, 0);
    checkOutput("reset_memory_out", memory_out, 0);
    checkOutput("reset_bus_err", bus_err, 0);
    checkOutput("reset_dmem_req", dmem_bus.req, 0);
    checkOutput("reset_dmem_be", dmem_bus.be, 0);
    rst = 1'b1;

    for (int i = 0; i < 10; i++) applyStimulus(vecs[i]);

    // Timeout: no rvalid for 16 WAIT_RDATA cycles.
    startLoad(32'h600);
    waitCycles = 0;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (done) break;
      if (stall) waitCycles++;
      @(negedge clk);
    end
    checkOutput("timeout_done", done, 1);
    checkOutput("timeout_wait_cycles", waitCycles, 16);
    checkOutput("timeout_bus_err", bus_err, 1);
    checkOutput("timeout_memory_out", memory_out, 0);

    // rvalid on the last allowed WAIT_RDATA cycle wins over the timeout.
    startLoad(32'h604);
    repeat (15) @(negedge clk);
    #1 checkOutput("late_rvalid_not_done", done, 0);
    dmem_bus.rvalid = 1'b1;
    dmem_bus.rdata  = 32'h13579BDF;
    @(negedge clk);
    dmem_bus.rvalid = 1'b0;
    dmem_bus.rdata  = 32'h0;
    #1;
    checkOutput("late_rvalid_done", done, 1);
    checkOutput("late_rvalid_bus_err", bus_err, 0);
    checkOutput("late_rvalid_memory_out", memory_out, 32'h13579BDF);

    // Reset in WAIT_RDATA, then a stray rvalid, then a normal load.
    startLoad(32'h700);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("rst_mid_stall", stall, 0);
    checkOutput("rst_mid_memory_out", memory_out, 0);
    checkOutput("rst_mid_dmem_req", dmem_bus.req, 0);
    checkOutput("rst_mid_done", done, 0);
    @(negedge clk);
    rst             = 1'b1;
    dmem_bus.rvalid = 1'b1;
    dmem_bus.rdata  = 32'hFFFFFFFF;
    @(negedge clk);
    dmem_bus.rvalid = 1'b0;
    dmem_bus.rdata  = 32'h0;
    #1;
    checkOutput("rst_stray_done", done, 0);
    checkOutput("rst_stray_memory_out", memory_out, 0);
    checkOutput("rst_stray_stall", stall, 0);
    applyStimulus('{"lw_after_rst", 1'b0, 1'b1, 3'b010, 32'h704, 32'h0, 32'h0BADF00D, 0, 4'b1111, 32'h704, 32'h0, 32'h0BADF00D});

`ifdef MEM_ACCESS_MISALIGN_EN
    @(negedge clk);
    req_valid = 1'b1;
    MemtoReg  = 1'b1;
    MemOP     = MEMOP_LW;
    addr      = 32'h101;
    #1 checkOutput("mis_stall_idle", stall, 1);
    @(negedge clk);
    req_valid = 1'b0;
    MemtoReg  = 1'b0;
    #1;
    checkOutput("mis_done", done, 1);
    checkOutput("mis_flag", misalign, 1);
    checkOutput("mis_dmem_req", dmem_bus.req, 0);
    checkOutput("mis_memory_out", memory_out, 32'h0BADF00D);
`else
    mv = '{"lw_forced_align", 1'b0, 1'b1, 3'b010, 32'h101, 32'h0, 32'h55AA55AA, 0, 4'b1111, 32'h100, 32'h0, 32'h55AA55AA};
    applyStimulus(mv);
`endif

    // Illegal MemOP skips the bus; a request during DONE is not accepted.
    @(negedge clk);
    req_valid = 1'b1;
    MemtoReg  = 1'b1;
    MemOP     = 3'b011;
    addr      = 32'h800;
    #1 checkOutput("illegal_stall_idle", stall, 1);
    @(negedge clk);
    MemOP = MEMOP_LW;
    addr  = 32'h900;
    #1;
    checkOutput("illegal_done", done, 1);
    checkOutput("illegal_dmem_req", dmem_bus.req, 0);
    checkOutput("illegal_memory_out", memory_out, 0);
    checkOutput("illegal_stall_done", stall, 0);
    @(negedge clk);
    req_valid = 1'b0;
    MemtoReg  = 1'b0;
    #1;
    checkOutput("done_req_ignored_dmem_req", dmem_bus.req, 0);
    checkOutput("done_req_ignored_stall", stall, 0);
    checkOutput("done_req_ignored_done", done, 0);

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
